// File: rtl/nco_quadwave_iq_if.sv
// Sample-stream interface of the quarter-wave I/Q NCO.
// The master side sets the tuning inputs and the downstream ready.
// The slave side (the NCO) returns valid and the signed sin/cos samples.
interface nco_quadwave_iq_if #(
    parameter int DATA_W  = 8,
    parameter int PHASE_W = 24
);
    logic                     i_enable;
    logic [PHASE_W-1:0]       i_fcw;
    logic [PHASE_W-1:0]       i_phase_off;
    logic                     i_sync;
    logic                     i_ready;
    logic                     o_valid;
    logic signed [DATA_W-1:0] o_sin;
    logic signed [DATA_W-1:0] o_cos;

    modport master (
        output i_enable, i_fcw, i_phase_off, i_sync, i_ready,
        input  o_valid, o_sin, o_cos
    );

    modport slave (
        input  i_enable, i_fcw, i_phase_off, i_sync, i_ready,
        output o_valid, o_sin, o_cos
    );
endinterface

// File: rtl/nco_quadwave_iq.sv
// Quarter-wave numerically controlled oscillator with phase-coherent sin/cos outputs.
// A phase accumulator is stepped by a programmable frequency word. A phase offset is
// added before lookup, and the sync input restarts the accumulator.
// Both waves come from one quarter-sine table through quadrant mirroring and negation.
// A three-stage pipeline (address, table read, output) stalls as a whole under
// output backpressure.
// The table is computed at elaboration from round(A*sin(pi/2*(k+0.5)/2**LUT_AW)),
// where A = 2**(DATA_W-1)-1, so no external memory image is needed.
// PHASE_W must be at least LUT_AW+2.
module nco_quadwave_iq #(
    parameter int DATA_W  = 8,
    parameter int LUT_AW  = 10,
    parameter int PHASE_W = 24
) (
    input  logic            clock,
    input  logic            i_reset,
    nco_quadwave_iq_if.slave bus
);
    localparam int DEPTH  = 1 << LUT_AW;
    localparam int TAB_W  = DATA_W - 1;
    localparam int ADDR_W = LUT_AW + 2;
    localparam int LOW_W  = PHASE_W - ADDR_W;

    function automatic logic [TAB_W-1:0] quarter_sin(input int k);
        real amp;
        real angle;
        amp   = real'((1 << TAB_W) - 1);
        angle = 3.14159265358979323846 / 2.0 * (real'(k) + 0.5) / real'(DEPTH);
        return TAB_W'($rtoi(amp * $sin(angle) + 0.5));
    endfunction

    // Shared quarter-sine table; every entry is an elaboration-time constant.
    logic [TAB_W-1:0] rom [DEPTH];
    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        localparam logic [TAB_W-1:0] VALUE = quarter_sin(k);
        assign rom[k] = VALUE;
    end

    logic               advance;
    logic               issue;
    logic [PHASE_W-1:0] acc;
    logic [PHASE_W-1:0] acc_eff;
    logic [PHASE_W-1:0] phase;
    logic [ADDR_W-1:0]  addr;

    // The pipeline moves when the output slot is empty or is being consumed.
    assign advance = !bus.o_valid || bus.i_ready;
    assign issue   = advance && bus.i_enable;
    assign acc_eff = bus.i_sync ? '0 : acc;
    assign phase   = acc_eff + bus.i_phase_off;
    // Low phase bits are dropped (truncation, not rounding).
    assign addr    = ADDR_W'(phase >> LOW_W);

    logic              s1_valid;
    logic [1:0]        s1_q;
    logic [LUT_AW-1:0] s1_idx;
    logic [LUT_AW-1:0] s1_idx_n;

    // Accumulator step and stage 1: capture quadrant and mirrored table addresses.
    always_ff @(posedge clock) begin
        // NOTE: every register is assigned with <= so all stages sample the
        // pre-edge values and shift together instead of racing through.
        if (i_reset) begin
            acc      <= '0;
            s1_valid <= 1'b0;
            s1_q     <= '0;
            s1_idx   <= '0;
            s1_idx_n <= '0;
        end else begin
            if (advance) begin
                s1_valid <= bus.i_enable;
            end
            if (issue) begin
                acc      <= acc_eff + bus.i_fcw;
                s1_q     <= addr[ADDR_W-1 -: 2];
                s1_idx   <= addr[LUT_AW-1:0];
                s1_idx_n <= ~addr[LUT_AW-1:0];
            end
        end
    end

    logic             s2_valid;
    logic [1:0]       s2_q;
    logic [TAB_W-1:0] s2_t_idx;
    logic [TAB_W-1:0] s2_t_inv;

    // Stage 2 control: valid and quadrant travel alongside the table read.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            s2_valid <= 1'b0;
            s2_q     <= '0;
        end else if (advance) begin
            s2_valid <= s1_valid;
            s2_q     <= s1_q;
        end
    end

    // Stage 2 data: synchronous reads of T[idx] and T[~idx].
    always_ff @(posedge clock) begin
        // NOTE: the table read registers carry no reset; a stage valid always
        // qualifies them, and leaving them unreset keeps them mappable to block ROM.
        if (advance) begin
            s2_t_idx <= rom[s1_idx];
            s2_t_inv <= rom[s1_idx_n];
        end
    end

    logic signed [DATA_W-1:0] t_idx_s;
    logic signed [DATA_W-1:0] t_inv_s;
    logic signed [DATA_W-1:0] sin_next;
    logic signed [DATA_W-1:0] cos_next;

    // Table entries are non-negative, so the zero-extended value is a safe signed operand.
    assign t_idx_s = signed'({1'b0, s2_t_idx});
    assign t_inv_s = signed'({1'b0, s2_t_inv});

    // Quadrant map: mirror the address and/or negate to rebuild the full period.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        sin_next = t_idx_s;
        cos_next = t_inv_s;
        unique case (s2_q)
            2'd0: begin
                sin_next = t_idx_s;
                cos_next = t_inv_s;
            end
            2'd1: begin
                sin_next = t_inv_s;
                cos_next = -t_idx_s;
            end
            2'd2: begin
                sin_next = -t_idx_s;
                cos_next = -t_inv_s;
            end
            2'd3: begin
                sin_next = -t_inv_s;
                cos_next = t_idx_s;
            end
            default: begin
                sin_next = t_idx_s;
                cos_next = t_inv_s;
            end
        endcase
    end

    // Stage 3: output registers; data only updates when a real sample arrives.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            bus.o_valid <= 1'b0;
            bus.o_sin   <= '0;
            bus.o_cos   <= '0;
        end else if (advance) begin
            bus.o_valid <= s2_valid;
            if (s2_valid) begin
                bus.o_sin <= sin_next;
                bus.o_cos <= cos_next;
            end
        end
    end
endmodule

// File: tb/tb_nco_quadwave_iq.sv
// Self-checking bench for nco_quadwave_iq: directed scenarios plus a randomized run.
// The randomized run is scored against a sample-level reference model.
module tb_nco_quadwave_iq;
    localparam int DATA_W  = 8;
    localparam int LUT_AW  = 10;
    localparam int PHASE_W = 24;
    localparam int DEPTH   = 1 << LUT_AW;
    localparam int QUAD    = 1 << (PHASE_W - 2);
    localparam int STEP    = 1 << (PHASE_W - 2 - LUT_AW);
    localparam real PI     = 3.14159265358979323846;

    logic clock = 1'b0;
    logic i_reset;

    nco_quadwave_iq_if #(.DATA_W(DATA_W), .PHASE_W(PHASE_W)) bus ();

    nco_quadwave_iq #(.DATA_W(DATA_W), .LUT_AW(LUT_AW), .PHASE_W(PHASE_W)) dut (
        .clock  (clock),
        .i_reset(i_reset),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference: the quarter table as defined, and a sample-level pipeline of depth 3.
    int ref_tab [DEPTH];
    typedef struct {
        bit v;
        int s;
        int c;
    } smp_t;
    smp_t m_pipe [3];
    logic [PHASE_W-1:0] m_acc;

    logic signed [DATA_W-1:0] obs_s [4100];
    logic signed [DATA_W-1:0] obs_c [4100];

    // Expected (sin, cos) from the phase: quadrant select, then mirror/negate.
    function automatic void ref_sample(input logic [PHASE_W-1:0] p, output int s, output int c);
        int q, idx, a, b;
        q   = int'(p / QUAD);
        idx = int'((p % QUAD) / STEP);
        a   = ref_tab[idx];
        b   = ref_tab[DEPTH - 1 - idx];
        case (q)
            0:       begin s = a;  c = b;  end
            1:       begin s = b;  c = -a; end
            2:       begin s = -a; c = -b; end
            default: begin s = -b; c = a;  end
        endcase
    endfunction

    task automatic model_update();
        logic [PHASE_W-1:0] eff, p;
        int s, c;
        if (i_reset) begin
            foreach (m_pipe[i]) m_pipe[i] = '{v: 1'b0, s: 0, c: 0};
            m_acc = '0;
        end else if (!m_pipe[2].v || bus.i_ready) begin
            m_pipe[2] = m_pipe[1];
            m_pipe[1] = m_pipe[0];
            if (bus.i_enable) begin
                eff = bus.i_sync ? '0 : m_acc;
                p   = eff + bus.i_phase_off;
                ref_sample(p, s, c);
                m_pipe[0] = '{v: 1'b1, s: s, c: c};
                m_acc = eff + bus.i_fcw;
            end else begin
                m_pipe[0].v = 1'b0;
            end
        end
    endtask

    // One clock edge: advance the model with the inputs present at the edge, then settle.
    task automatic step();
        model_update();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
    endtask

    task automatic setup(input int fcw, input int off);
        bus.i_fcw       = PHASE_W'(fcw);
        bus.i_phase_off = PHASE_W'(off);
        bus.i_sync      = 1'b0;
        bus.i_enable    = 1'b1;
        bus.i_ready     = 1'b1;
    endtask

    int exp_s [4] = '{0, 127, 0, -127};
    int exp_c [4] = '{127, 0, -127, 0};

    task automatic test_reset();
        bus.i_enable = 1'b1;
        bus.i_ready  = 1'b1;
        i_reset = 1'b1;
        step();
        step();
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o_sin !== 8'sd0 || bus.o_cos !== 8'sd0) begin
            errors++;
            $display("FAIL reset_state: got valid=%0b sin=%0d cos=%0d want 0 0 0",
                     bus.o_valid, bus.o_sin, bus.o_cos);
        end
        i_reset = 1'b0;
    endtask

    task automatic test_quadrature();
        logic want_v;
        int n;
        do_reset();
        setup(QUAD, 0);
        for (int e = 0; e < 14; e++) begin
            step();
            want_v = (e >= 2);
            checks++;
            if (bus.o_valid !== want_v) begin
                errors++;
                $display("FAIL quad_valid edge %0d: got %0b want %0b", e, bus.o_valid, want_v);
            end
            if (e >= 2) begin
                n = e - 2;
                checks++;
                if (bus.o_sin !== 8'(exp_s[n % 4]) || bus.o_cos !== 8'(exp_c[n % 4])) begin
                    errors++;
                    $display("FAIL quad_seq sample %0d: got (%0d,%0d) want (%0d,%0d)",
                             n, bus.o_sin, bus.o_cos, exp_s[n % 4], exp_c[n % 4]);
                end
            end
        end
    endtask

    task automatic test_full_period();
        logic signed [DATA_W-1:0] ws, wc;
        int n;
        n = 0;
        do_reset();
        setup(STEP, 0);
        for (int e = 0; e < 4200 && n < 4100; e++) begin
            step();
            checks++;
            if (bus.o_valid !== m_pipe[2].v) begin
                errors++;
                $display("FAIL period_valid edge %0d: got %0b want %0b", e, bus.o_valid, m_pipe[2].v);
            end
            if (bus.o_valid === 1'b1) begin
                ws = DATA_W'(m_pipe[2].s);
                wc = DATA_W'(m_pipe[2].c);
                checks++;
                if (bus.o_sin !== ws || bus.o_cos !== wc) begin
                    errors++;
                    $display("FAIL period_model sample %0d: got (%0d,%0d) want (%0d,%0d)",
                             n, bus.o_sin, bus.o_cos, ws, wc);
                end
                obs_s[n] = bus.o_sin;
                obs_c[n] = bus.o_cos;
                n++;
            end
        end
        checks++;
        if (n != 4100) begin
            errors++;
            $display("FAIL period_count: got %0d samples want 4100", n);
        end else begin
            checks++;
            if (obs_s[0] !== 8'sd0 || obs_c[0] !== 8'sd127) begin
                errors++;
                $display("FAIL period_s0: got (%0d,%0d) want (0,127)", obs_s[0], obs_c[0]);
            end
            checks++;
            if (obs_s[1024] !== 8'sd127 || obs_c[1024] !== 8'sd0) begin
                errors++;
                $display("FAIL period_s1024: got (%0d,%0d) want (127,0)", obs_s[1024], obs_c[1024]);
            end
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (obs_s[k + 4096] !== obs_s[k] || obs_c[k + 4096] !== obs_c[k]) begin
                    errors++;
                    $display("FAIL period_repeat %0d: got (%0d,%0d) want (%0d,%0d)",
                             k, obs_s[k + 4096], obs_c[k + 4096], obs_s[k], obs_c[k]);
                end
            end
        end
    endtask

    task automatic test_offset();
        int n;
        do_reset();
        setup(QUAD, QUAD);
        for (int e = 0; e < 10; e++) begin
            step();
            if (e >= 2) begin
                n = e - 2 + 1;
                checks++;
                if (bus.o_valid !== 1'b1 || bus.o_sin !== 8'(exp_s[n % 4]) ||
                    bus.o_cos !== 8'(exp_c[n % 4])) begin
                    errors++;
                    $display("FAIL offset_seq sample %0d: got v=%0b (%0d,%0d) want v=1 (%0d,%0d)",
                             e - 2, bus.o_valid, bus.o_sin, bus.o_cos, exp_s[n % 4], exp_c[n % 4]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic                     cap_v;
        logic signed [DATA_W-1:0] cap_s, cap_c;
        int cons;
        cons = 0;
        do_reset();
        setup(QUAD, 0);
        for (int e = 0; e < 30; e++) begin
            bus.i_ready = !(e >= 8 && e < 13);
            if (e == 8) begin
                cap_v = bus.o_valid;
                cap_s = bus.o_sin;
                cap_c = bus.o_cos;
            end
            if (e > 8 && e <= 13) begin
                checks++;
                if (bus.o_valid !== cap_v || bus.o_sin !== cap_s || bus.o_cos !== cap_c) begin
                    errors++;
                    $display("FAIL stall_frozen cycle %0d: got v=%0b (%0d,%0d) want v=%0b (%0d,%0d)",
                             e, bus.o_valid, bus.o_sin, bus.o_cos, cap_v, cap_s, cap_c);
                end
            end
            if (bus.o_valid === 1'b1 && bus.i_ready) begin
                checks++;
                if (bus.o_sin !== 8'(exp_s[cons % 4]) || bus.o_cos !== 8'(exp_c[cons % 4])) begin
                    errors++;
                    $display("FAIL stall_seq sample %0d: got (%0d,%0d) want (%0d,%0d)",
                             cons, bus.o_sin, bus.o_cos, exp_s[cons % 4], exp_c[cons % 4]);
                end
                cons++;
            end
            step();
        end
        checks++;
        if (cons != 22) begin
            errors++;
            $display("FAIL stall_count: got %0d consumed want 22", cons);
        end
        bus.i_ready = 1'b1;
    endtask

    task automatic test_sync();
        int k, j;
        do_reset();
        setup(QUAD, 0);
        for (int e = 0; e < 16; e++) begin
            bus.i_sync = (e == 5);
            step();
            if (e >= 2) begin
                k = e - 2;
                j = (k < 5) ? k % 4 : (k - 5) % 4;
                checks++;
                if (bus.o_valid !== 1'b1 || bus.o_sin !== 8'(exp_s[j]) || bus.o_cos !== 8'(exp_c[j])) begin
                    errors++;
                    $display("FAIL sync_seq sample %0d: got v=%0b (%0d,%0d) want v=1 (%0d,%0d)",
                             k, bus.o_valid, bus.o_sin, bus.o_cos, exp_s[j], exp_c[j]);
                end
            end
        end
        bus.i_sync = 1'b0;
    endtask

    task automatic test_mid_reset();
        logic want_v;
        do_reset();
        setup(QUAD, 0);
        for (int e = 0; e < 7; e++) step();
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o_sin !== 8'sd0 || bus.o_cos !== 8'sd0) begin
            errors++;
            $display("FAIL midreset_clear: got v=%0b (%0d,%0d) want v=0 (0,0)",
                     bus.o_valid, bus.o_sin, bus.o_cos);
        end
        for (int e = 0; e < 3; e++) begin
            step();
            want_v = (e == 2);
            checks++;
            if (bus.o_valid !== want_v) begin
                errors++;
                $display("FAIL midreset_valid edge %0d: got %0b want %0b", e, bus.o_valid, want_v);
            end
        end
        checks++;
        if (bus.o_sin !== 8'sd0 || bus.o_cos !== 8'sd127) begin
            errors++;
            $display("FAIL midreset_first: got (%0d,%0d) want (0,127)", bus.o_sin, bus.o_cos);
        end
    endtask

    task automatic test_random();
        logic signed [DATA_W-1:0] ws, wc;
        do_reset();
        setup(QUAD, 0);
        for (int e = 0; e < 3000; e++) begin
            bus.i_enable = ($urandom_range(0, 3) != 0);
            bus.i_ready  = ($urandom_range(0, 9) < 7);
            bus.i_sync   = ($urandom_range(0, 19) == 0);
            bus.i_fcw    = PHASE_W'($urandom);
            if ($urandom_range(0, 15) == 0) bus.i_phase_off = PHASE_W'($urandom);
            i_reset      = ($urandom_range(0, 299) == 0);
            step();
            checks++;
            if (bus.o_valid !== m_pipe[2].v) begin
                errors++;
                $display("FAIL random_valid cycle %0d: got %0b want %0b", e, bus.o_valid, m_pipe[2].v);
            end
            if (m_pipe[2].v) begin
                ws = DATA_W'(m_pipe[2].s);
                wc = DATA_W'(m_pipe[2].c);
                checks++;
                if (bus.o_sin !== ws || bus.o_cos !== wc) begin
                    errors++;
                    $display("FAIL random_data cycle %0d: got (%0d,%0d) want (%0d,%0d)",
                             e, bus.o_sin, bus.o_cos, ws, wc);
                end
            end
        end
        i_reset = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < DEPTH; k++) begin
            ref_tab[k] = $rtoi(127.0 * $sin(PI / 2.0 * (real'(k) + 0.5) / real'(DEPTH)) + 0.5);
        end
        i_reset         = 1'b1;
        bus.i_enable    = 1'b0;
        bus.i_fcw       = '0;
        bus.i_phase_off = '0;
        bus.i_sync      = 1'b0;
        bus.i_ready     = 1'b0;
        foreach (m_pipe[i]) m_pipe[i] = '{v: 1'b0, s: 0, c: 0};
        m_acc = '0;

        test_reset();
        test_quadrature();
        test_full_period();
        test_offset();
        test_backpressure();
        test_sync();
        test_mid_reset();
        test_random();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
